// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator/resolver: funct3 compare, mispredict check, redirect PC.
// Define BR_PERF_CNT_EN to add saturating branch/mispredict performance counters.
module branch_cmp_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cmpop,
  input  logic [WIDTH-1:0]  rs1,
  input  logic [WIDTH-1:0]  rs2,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic              pred_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_br_en,
  output logic              out_mispredict,
  output logic [ADDR_W-1:0] out_redirect,
  output logic              out_illegal
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);

  typedef enum logic [2:0] {
    CmpBeq  = 3'b000,
    CmpBne  = 3'b001,
    CmpBlt  = 3'b100,
    CmpBge  = 3'b101,
    CmpBltu = 3'b110,
    CmpBgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic              br_en;
    logic              mispredict;
    logic              illegal;
    logic [ADDR_W-1:0] redirect;
  } res_t;

  res_t                   res_d;
  res_t                   stage_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] stage_rdy;
  logic                   in_fire;
  logic                   eq, lt_s, lt_u;
  logic                   taken, illegal;
  logic                   rdy_chain;

  // Resolution happens entirely ahead of stage 1; later stages only carry the result.
  always_comb begin
    eq      = (rs1 == rs2);
    lt_s    = ($signed(rs1) < $signed(rs2));
    lt_u    = (rs1 < rs2);
    taken   = 1'b0;
    illegal = 1'b0;
    case (cmpop)
      CmpBeq:  taken = eq;
      CmpBne:  taken = !eq;
      CmpBlt:  taken = lt_s;
      CmpBge:  taken = !lt_s;
      CmpBltu: taken = lt_u;
      CmpBgeu: taken = !lt_u;
      default: illegal = 1'b1;
    endcase
    res_d.br_en      = taken;
    res_d.illegal    = illegal;
    res_d.mispredict = (taken != pred_taken) || illegal;
    res_d.redirect   = taken ? target : (pc + ADDR_W'(4));
  end

  // A stage can take new data when it is empty or its content moves on this cycle.
  always_comb begin
    stage_rdy = '0;
    rdy_chain = out_ready;
    for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
      rdy_chain    = !valid_q[k] || rdy_chain;
      stage_rdy[k] = rdy_chain;
    end
  end

  assign in_ready = rst && !flush && stage_rdy[0];
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      if (stage_rdy[0]) begin
        valid_q[0] <= in_fire;
        if (in_fire) begin
          stage_q[0] <= res_d;
        end
      end
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        if (stage_rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            stage_q[k] <= stage_q[k-1];
          end
        end
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  assign out_valid      = valid_q[PIPE_STAGES-1];
  assign out_br_en      = stage_q[PIPE_STAGES-1].br_en;
  assign out_mispredict = stage_q[PIPE_STAGES-1].mispredict;
  assign out_illegal    = stage_q[PIPE_STAGES-1].illegal;
  assign out_redirect   = stage_q[PIPE_STAGES-1].redirect;

`ifdef BR_PERF_CNT_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // Counters saturate rather than wrap and ignore flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (out_xfer) begin
      if (perf_branches != 32'hFFFF_FFFF) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (out_mispredict && (perf_mispredicts != 32'hFFFF_FFFF)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Scoreboard bench for branch_cmp_pipe: expected results are queued at input acceptance and
// compared in order on each output transfer; flush/reset empty the queue.
module tb_branch_cmp_pipe;

  localparam int unsigned Stages = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, pred_taken;
  logic [2:0]  cmpop;
  logic [31:0] rs1, rs2, pc, target;
  logic        out_valid, out_ready, out_br_en, out_mispredict, out_illegal;
  logic [31:0] out_redirect;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
  int unsigned exp_br = 0, exp_mis = 0;
`endif

  typedef struct packed {
    logic        br_en;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(
    .WIDTH      (32),
    .ADDR_W     (32),
    .PIPE_STAGES(Stages)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cmpop         (cmpop),
    .rs1           (rs1),
    .rs2           (rs2),
    .pc            (pc),
    .target        (target),
    .pred_taken    (pred_taken),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_br_en     (out_br_en),
    .out_mispredict(out_mispredict),
    .out_redirect  (out_redirect),
    .out_illegal   (out_illegal)
`ifdef BR_PERF_CNT_EN
    ,
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p, input logic [31:0] t, input logic pred);
    exp_t e;
    logic tk;
    e.ill = 1'b0;
    tk    = 1'b0;
    case (op)
      3'b000:  tk = (a == b);
      3'b001:  tk = (a != b);
      3'b100:  tk = ($signed(a) < $signed(b));
      3'b101:  tk = !($signed(a) < $signed(b));
      3'b110:  tk = (a < b);
      3'b111:  tk = !(a < b);
      default: e.ill = 1'b1;
    endcase
    e.br_en = tk;
    e.mis   = (tk != pred) || e.ill;
    e.redir = tk ? t : p + 32'd4;
    return e;
  endfunction

  // Monitor: everything sampled on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      sb.delete();
    end else begin
      // Input stalls only when every stage holds an entry and the output is stalled.
      check_eq("in_ready", 64'(in_ready),
               64'(!flush && ((sb.size() < Stages) || out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("br_en", 64'(out_br_en), 64'(e.br_en));
          check_eq("mispredict", 64'(out_mispredict), 64'(e.mis));
          check_eq("illegal", 64'(out_illegal), 64'(e.ill));
          check_eq("redirect", 64'(out_redirect), 64'(e.redir));
`ifdef BR_PERF_CNT_EN
          exp_br++;
          if (e.mis) exp_mis++;
`endif
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(cmpop, rs1, rs2, pc, target, pred_taken));
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] t, input logic pred);
    int w = 0;
    cmpop = op; rs1 = a; rs2 = b; pc = p; target = t; pred_taken = pred;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1 check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cmpop = '0; rs1 = '0; rs2 = '0; pc = '0; target = '0; pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready_d", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("post_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("post_rst_outs", {out_br_en, out_mispredict, out_illegal, out_redirect}, 64'd0);
    @(posedge clk); #1;

    // Exact latency: beq taken against a not-taken prediction.
    send(3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0);
    for (int i = 1; i < Stages; i++) begin
      check_eq("lat_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("lat_br_en", 64'(out_br_en), 64'd1);
    check_eq("lat_mis", 64'(out_mispredict), 64'd1);
    check_eq("lat_redir", 64'(out_redirect), 64'h100);
    wait_drain();

    // Signed vs unsigned, back to back.
    send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b1);
    send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h300, 1'b1);
    send(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h300, 1'b0);
    send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20C, 32'h300, 1'b0);
    send(3'b001, 32'h1234, 32'h1235, 32'h210, 32'h400, 1'b1);
    // Illegal op with PC wrap.
    send(3'b010, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h500, 1'b0);
    send(3'b011, 32'd7, 32'd7, 32'h10, 32'h500, 1'b1);
    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(7)), $urandom, (i % 3 == 0) ? 32'hA5 : $urandom,
           $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom));
    end
    wait_drain();

    // Six back-to-back branches with the output stalled for four cycles.
    fork
      for (int i = 0; i < 6; i++) send(3'($urandom_range(4, 7)), $urandom, $urandom, 32'h1000 + 32'(i * 4), 32'h2000, 1'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with two in flight and a competing input.
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, 32'h60, 32'h70, 1'b0);
    send(3'b001, 32'd1, 32'd2, 32'h64, 32'h74, 1'b0);
    flush = 1'b1; in_valid = 1'b1; cmpop = 3'b000;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (Stages + 3) @(posedge clk);
    #1 check_eq("flush_quiet", 64'(out_valid), 64'd0);

    // Reset mid-stream discards entries.
    out_ready = 1'b0;
    send(3'b000, 32'd3, 32'd3, 32'h80, 32'h90, 1'b1);
    send(3'b000, 32'd3, 32'd4, 32'h84, 32'h94, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;
    check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_mid_redir", 64'(out_redirect), 64'd0);
`ifdef BR_PERF_CNT_EN
    exp_br = 0; exp_mis = 0;
`endif
    repeat (Stages + 3) @(posedge clk);
    #1 check_eq("rst_mid_quiet", 64'(out_valid), 64'd0);
    send(3'b101, 32'd9, 32'd2, 32'hC0, 32'hD0, 1'b1);
    wait_drain();
`ifdef BR_PERF_CNT_EN
    check_eq("perf_branches", 64'(perf_branches), 64'(exp_br));
    check_eq("perf_mispredicts", 64'(perf_mispredicts), 64'(exp_mis));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
